// File: rtl/mfp_ahb_sdram_front.sv
// AHB-Lite slave front end of the SDRAM subsystem: turns bus transfers into command/write-data FIFO
// pushes and returns read data popped from the read-data FIFO, one transfer outstanding at a time.
module mfp_ahb_sdram_front #(
  parameter int CMD_WIDTH      = 36,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_SIZE        = 16,
  parameter int DROP_SIZE      = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HSIZE,
  input  logic                 HWRITE,
  input  logic                 HREADY,
  input  logic [31:0]          HWDATA,
  output logic [31:0]          HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic                 CFIFO_WEN,
  output logic [CMD_WIDTH-1:0] CFIFO_WDATA,
  input  logic                 CFIFO_WFULL,
  output logic                 WFIFO_WEN,
  output logic [31:0]          WFIFO_WDATA,
  input  logic                 WFIFO_WFULL,
  output logic                 RFIFO_REN,
  input  logic [31:0]          RFIFO_RDATA,
  input  logic                 RFIFO_REMPTY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RCMD, S_RWAIT, S_RDATA, S_RDONE, S_ERR0, S_ERR1
  } state_t;

  state_t               state;
  logic [31:0]          addr_q;
  logic [2:0]           size_q;
  logic                 wr_q;
  logic [TO_SIZE-1:0]   timer;
  logic [DROP_SIZE-1:0] drop;

  logic        accept;
  logic        wr_ok;
  logic        take;
  logic [35:0] cmd_word;
  logic        unused_htrans0;

  assign unused_htrans0 = HTRANS[0];
  assign accept   = HSEL & HTRANS[1] & HREADY;
  assign wr_ok    = ~CFIFO_WFULL & ~WFIFO_WFULL;
  assign take     = accept & ((state == S_IDLE) | (state == S_RDONE) | ((state == S_WRITE) & wr_ok));
  assign cmd_word = {wr_q, size_q, addr_q};

  assign CFIFO_WDATA = CMD_WIDTH'(cmd_word);
  assign WFIFO_WDATA = HWDATA;

  always_comb begin
    HREADYOUT = 1'b0;
    HRESP     = 1'b0;
    CFIFO_WEN = 1'b0;
    WFIFO_WEN = 1'b0;
    RFIFO_REN = 1'b0;
    case (state)
      S_IDLE: begin
        HREADYOUT = 1'b1;
        RFIFO_REN = (drop != '0) & ~RFIFO_REMPTY;
      end
      S_WRITE: begin
        HREADYOUT = wr_ok;
        CFIFO_WEN = wr_ok;
        WFIFO_WEN = wr_ok;
      end
      S_RCMD:  CFIFO_WEN = ~CFIFO_WFULL;
      S_RWAIT: RFIFO_REN = ~RFIFO_REMPTY;
      S_RDONE: HREADYOUT = 1'b1;
      S_ERR0:  HRESP = 1'b1;
      S_ERR1: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state  <= S_IDLE;
      addr_q <= '0;
      size_q <= '0;
      wr_q   <= 1'b0;
      timer  <= '0;
      drop   <= '0;
      HRDATA <= '0;
    end else begin
      case (state)
        S_IDLE:  if (RFIFO_REN) drop <= drop - 1'b1;
        S_WRITE: if (wr_ok) state <= S_IDLE;
        S_RCMD: begin
          if (!CFIFO_WFULL) begin
            timer <= TO_SIZE'(TIMEOUT_CYCLES);
            state <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (!RFIFO_REMPTY) begin
            // A non-zero drop count means this word belongs to an earlier, timed-out read.
            if (drop == '0) begin
              state <= S_RDATA;
            end else begin
              drop  <= drop - 1'b1;
              timer <= TO_SIZE'(TIMEOUT_CYCLES);
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            if (timer <= TO_SIZE'(1)) begin
              if (drop != '1) drop <= drop + 1'b1;
              state <= S_ERR0;
            end else begin
              timer <= timer - 1'b1;
            end
          end
        end
        S_RDATA: begin
          HRDATA <= RFIFO_RDATA;
          state  <= S_RDONE;
        end
        S_RDONE: state <= S_IDLE;
        S_ERR0:  state <= S_ERR1;
        S_ERR1:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (take) begin
        addr_q <= HADDR;
        size_q <= HSIZE;
        wr_q   <= HWRITE;
        state  <= HWRITE ? S_WRITE : S_RCMD;
      end
    end
  end

endmodule

// File: tb/tb_mfp_ahb_sdram_front.sv
// Directed bench for mfp_ahb_sdram_front: write vectors from a table, read/timeout/reset as sequences.
module tb_mfp_ahb_sdram_front;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        CFIFO_WEN;
  logic [35:0] CFIFO_WDATA;
  logic        CFIFO_WFULL;
  logic        WFIFO_WEN;
  logic [31:0] WFIFO_WDATA;
  logic        WFIFO_WFULL;
  logic        RFIFO_REN;
  logic [31:0] RFIFO_RDATA;
  logic        RFIFO_REMPTY;

  always #5 HCLK = ~HCLK;

  mfp_ahb_sdram_front #(.CMD_WIDTH(36), .TIMEOUT_CYCLES(8), .TO_SIZE(16), .DROP_SIZE(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .CFIFO_WEN(CFIFO_WEN), .CFIFO_WDATA(CFIFO_WDATA),
    .CFIFO_WFULL(CFIFO_WFULL), .WFIFO_WEN(WFIFO_WEN), .WFIFO_WDATA(WFIFO_WDATA),
    .WFIFO_WFULL(WFIFO_WFULL), .RFIFO_REN(RFIFO_REN), .RFIFO_RDATA(RFIFO_RDATA),
    .RFIFO_REMPTY(RFIFO_REMPTY)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Read-data FIFO model: queued words, plus an optional reply that lands 4 cycles after a read command push.
  logic [31:0] rf_q[$];
  int          arrive_in = 0;
  logic [31:0] arrive_word = '0;
  logic        rf_auto = 1'b0;

  typedef struct {
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready;
    logic        cfull;
    logic        wfull;
    logic        e_rdy;
    logic        e_cwen;
    logic        e_wwen;
    logic [35:0] e_cdat;
    logic [31:0] e_wdat;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic hsel, logic [1:0] htrans, logic hwrite, logic [2:0] hsize,
                              logic [31:0] haddr, logic [31:0] hwdata, logic hready, logic cfull,
                              logic wfull, logic e_rdy, logic e_cwen, logic e_wwen,
                              logic [35:0] e_cdat, logic [31:0] e_wdat);
    vec_t v;
    v.hsel = hsel; v.htrans = htrans; v.hwrite = hwrite; v.hsize = hsize; v.haddr = haddr;
    v.hwdata = hwdata; v.hready = hready; v.cfull = cfull; v.wfull = wfull; v.e_rdy = e_rdy;
    v.e_cwen = e_cwen; v.e_wwen = e_wwen; v.e_cdat = e_cdat; v.e_wdat = e_wdat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    logic ren, cen, cwr;
    ren = RFIFO_REN;
    cen = CFIFO_WEN;
    cwr = CFIFO_WDATA[35];
    @(posedge HCLK);
    #1;
    if (ren && rf_q.size() > 0) RFIFO_RDATA = rf_q.pop_front();
    if (arrive_in > 0) begin
      arrive_in--;
      if (arrive_in == 0) rf_q.push_back(arrive_word);
    end
    if (cen && !cwr && rf_auto) arrive_in = 4;
    RFIFO_REMPTY = (rf_q.size() == 0);
  endtask

  task automatic idle_in();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b000; HADDR = '0;
    HREADY = 1'b1; CFIFO_WFULL = 1'b0; WFIFO_WFULL = 1'b0;
  endtask

  // Issues a word read and runs until HREADYOUT or HRESP rises; low counts the OKAY wait cycles.
  task automatic do_read(input logic [31:0] a, output int low, output int rens, output int rbad);
    low = 0; rens = 0; rbad = 0;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'b010; HADDR = a;
    #1;
    chk("rd_addr_rdy", 64'(HREADYOUT), 64'd1);
    step();
    idle_in();
    #1;
    chk("rd_cmd_push", 64'(CFIFO_WEN), 64'd1);
    chk("rd_cmd_word", 64'(CFIFO_WDATA), 64'({1'b0, 3'b010, a}));
    for (int i = 0; i < 40 && !HREADYOUT && !HRESP; i++) begin
      low++;
      rens += int'(RFIFO_REN);
      step();
      #1;
    end
    chk("rd_bound", 64'(HREADYOUT | HRESP), 64'd1);
  endtask

  int low, rens, rbad;

  initial begin
    HRESETn = 1'b0;
    HWDATA = '0;
    RFIFO_RDATA = '0;
    RFIFO_REMPTY = 1'b1;
    idle_in();

    // Write-side vectors, one row per cycle; outputs checked before the closing edge.
    //          sel trn  wr size  addr          wdata         rdy cf wf  e_rdy cwen wwen  e_cdat          e_wdat
    tv.push_back(mk(1, 2'b10, 1, 3'd2, 32'h100, 32'h0,        1, 0, 0,  1, 0, 0, 36'h0,          32'h0));
    tv.push_back(mk(0, 2'b00, 0, 3'd0, 32'h0,   32'hDEADBEEF, 1, 0, 0,  1, 1, 1, 36'hA_0000_0100, 32'hDEADBEEF));
    tv.push_back(mk(0, 2'b00, 0, 3'd0, 32'h0,   32'h0,        1, 0, 0,  1, 0, 0, 36'h0,          32'h0));
    tv.push_back(mk(1, 2'b10, 1, 3'd0, 32'h3,   32'h0,        1, 0, 0,  1, 0, 0, 36'h0,          32'h0));
    tv.push_back(mk(1, 2'b10, 1, 3'd1, 32'h6,   32'hAA,       1, 0, 0,  1, 1, 1, 36'h8_0000_0003, 32'hAA));
    tv.push_back(mk(0, 2'b00, 0, 3'd0, 32'h0,   32'hBBBB,     1, 0, 0,  1, 1, 1, 36'h9_0000_0006, 32'hBBBB));
    tv.push_back(mk(0, 2'b00, 0, 3'd0, 32'h0,   32'h0,        1, 0, 0,  1, 0, 0, 36'h0,          32'h0));
    tv.push_back(mk(1, 2'b10, 1, 3'd2, 32'h40,  32'h0,        1, 0, 0,  1, 0, 0, 36'h0,          32'h0));
    for (int k = 0; k < 5; k++)
      tv.push_back(mk(0, 2'b00, 0, 3'd0, 32'h0, 32'h55AA55AA, 0, 0, 1,  0, 0, 0, 36'h0,          32'h0));
    tv.push_back(mk(0, 2'b00, 0, 3'd0, 32'h0,   32'h55AA55AA, 1, 0, 0,  1, 1, 1, 36'hA_0000_0040, 32'h55AA55AA));
    tv.push_back(mk(0, 2'b00, 0, 3'd0, 32'h0,   32'h0,        1, 0, 0,  1, 0, 0, 36'h0,          32'h0));
    tv.push_back(mk(1, 2'b10, 1, 3'd2, 32'h80,  32'h0,        1, 0, 0,  1, 0, 0, 36'h0,          32'h0));
    tv.push_back(mk(0, 2'b00, 0, 3'd0, 32'h0,   32'h11112222, 0, 1, 0,  0, 0, 0, 36'h0,          32'h0));
    tv.push_back(mk(0, 2'b00, 0, 3'd0, 32'h0,   32'h11112222, 0, 1, 1,  0, 0, 0, 36'h0,          32'h0));
    tv.push_back(mk(0, 2'b00, 0, 3'd0, 32'h0,   32'h11112222, 1, 0, 0,  1, 1, 1, 36'hA_0000_0080, 32'h11112222));
    // BUSY, unselected and HREADY-low transfers are ignored.
    tv.push_back(mk(1, 2'b01, 1, 3'd2, 32'hC0,  32'h0,        1, 0, 0,  1, 0, 0, 36'h0,          32'h0));
    tv.push_back(mk(0, 2'b10, 1, 3'd2, 32'hC4,  32'h0,        1, 0, 0,  1, 0, 0, 36'h0,          32'h0));
    tv.push_back(mk(1, 2'b10, 1, 3'd2, 32'hC8,  32'h0,        0, 0, 0,  1, 0, 0, 36'h0,          32'h0));
    tv.push_back(mk(0, 2'b00, 0, 3'd0, 32'h0,   32'h0,        1, 0, 0,  1, 0, 0, 36'h0,          32'h0));

    step();
    step();
    #1;
    chk("rst_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("rst_hresp",     64'(HRESP), 64'd0);
    chk("rst_hrdata",    64'(HRDATA), 64'd0);
    chk("rst_enables",   64'({CFIFO_WEN, WFIFO_WEN, RFIFO_REN}), 64'd0);
    HRESETn = 1'b1;
    step();

    foreach (tv[i]) begin
      HSEL = tv[i].hsel; HTRANS = tv[i].htrans; HWRITE = tv[i].hwrite; HSIZE = tv[i].hsize;
      HADDR = tv[i].haddr; HWDATA = tv[i].hwdata; HREADY = tv[i].hready;
      CFIFO_WFULL = tv[i].cfull; WFIFO_WFULL = tv[i].wfull;
      #1;
      chk($sformatf("wr%0d_rdy", i),  64'(HREADYOUT), 64'(tv[i].e_rdy));
      chk($sformatf("wr%0d_cwen", i), 64'(CFIFO_WEN), 64'(tv[i].e_cwen));
      chk($sformatf("wr%0d_wwen", i), 64'(WFIFO_WEN), 64'(tv[i].e_wwen));
      chk($sformatf("wr%0d_resp", i), 64'(HRESP), 64'd0);
      if (tv[i].e_cwen) chk($sformatf("wr%0d_cdat", i), 64'(CFIFO_WDATA), 64'(tv[i].e_cdat));
      if (tv[i].e_wwen) chk($sformatf("wr%0d_wdat", i), 64'(WFIFO_WDATA), 64'(tv[i].e_wdat));
      step();
    end
    idle_in();

    // Read with the reply landing 4 cycles after the command push: RCMD + 5 RWAIT + RDATA.
    rf_auto = 1'b1;
    arrive_word = 32'h12345678;
    do_read(32'h200, low, rens, rbad);
    chk("rd_low_cycles", 64'(low), 64'd7);
    chk("rd_ren_pulses", 64'(rens), 64'd1);
    chk("rd_hresp",      64'(HRESP), 64'd0);
    chk("rd_hrdata",     64'(HRDATA), 64'h12345678);
    step();
    #1;
    chk("rd_idle_rdy",   64'(HREADYOUT), 64'd1);
    chk("rd_hold",       64'(HRDATA), 64'h12345678);

    // Timeout: RCMD + 8 RWAIT OKAY wait cycles, then two ERROR cycles.
    rf_auto = 1'b0;
    do_read(32'h300, low, rens, rbad);
    chk("to_low_cycles", 64'(low), 64'd9);
    chk("to_err0", 64'({HREADYOUT, HRESP}), 64'b01);
    step();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'b010; HADDR = 32'h500;
    #1;
    chk("to_err1", 64'({HREADYOUT, HRESP}), 64'b11);
    step();
    idle_in();
    #1;
    chk("to_idle", 64'({HREADYOUT, HRESP}), 64'b10);
    chk("err1_no_accept", 64'(CFIFO_WEN), 64'd0);
    step();

    // Late word for the timed-out read is discarded in idle.
    rf_q.push_back(32'hBAD0BAD0);
    RFIFO_REMPTY = 1'b0;
    #1;
    chk("late_pop", 64'(RFIFO_REN), 64'd1);
    step();
    #1;
    chk("late_done", 64'(RFIFO_REN), 64'd0);
    chk("late_drained", 64'(rf_q.size()), 64'd0);

    rf_auto = 1'b1;
    arrive_word = 32'hCAFEF00D;
    do_read(32'h204, low, rens, rbad);
    chk("rd2_hrdata", 64'(HRDATA), 64'hCAFEF00D);
    chk("rd2_low", 64'(low), 64'd7);
    chk("rd2_resp_ok", 64'(rbad), 64'd0);
    step();

    // Leave a drop pending, then reset in the middle of the next read's wait.
    rf_auto = 1'b0;
    do_read(32'h308, low, rens, rbad);
    step();
    step();
    #1;
    chk("to2_idle_rdy", 64'(HREADYOUT), 64'd1);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'b010; HADDR = 32'h400;
    step();
    idle_in();
    step();
    step();
    #1;
    chk("rwait_stall", 64'(HREADYOUT), 64'd0);
    HRESETn = 1'b0;
    step();
    #1;
    chk("mid_rst_rdy",    64'(HREADYOUT), 64'd1);
    chk("mid_rst_hrdata", 64'(HRDATA), 64'd0);
    chk("mid_rst_resp",   64'(HRESP), 64'd0);
    chk("mid_rst_en",     64'({CFIFO_WEN, WFIFO_WEN, RFIFO_REN}), 64'd0);
    HRESETn = 1'b1;
    step();
    rf_q.push_back(32'h77);
    RFIFO_REMPTY = 1'b0;
    #1;
    chk("rst_drop_clear", 64'(RFIFO_REN), 64'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
